i2s_adc_rx: RTL
===============

Name: i2s_adc_rx

Overview:
Parametrised stereo I2S/left-justified serial ADC receiver for the codec audio path, clocked by the codec bit clock. Deserialises both channels of each LRC frame into parallel words and emits a one-cycle frame strobe. Generates a saturating sample address and write strobe for the SRAM record buffer, and flags malformed frames.

Parameters:
DATA_W, 16, sample width per channel (8..24); bits beyond DATA_W in a slot are ignored
ADDR_W, 18, record address width
MODE, 0, 0 = I2S (MSB one bclk after LRC edge), 1 = left-justified (MSB on LRC edge)

Ports:
bclk  in  1  codec bit clock; all logic on posedge
reset  in  1  asynchronous, active-high reset
adclrc  in  1  LRC: low = left slot, high = right slot
adcdat  in  1  serial data, MSB first
record  in  1  record enable
data_l  out  DATA_W  last complete left sample
data_r  out  DATA_W  last complete right sample
sample_valid  out  1  one-bclk pulse on new L/R pair
wr  out  1  write strobe to buffer (= sample_valid & record_q & ~full)
addr  out  ADDR_W  buffer address for the current wr
full  out  1  address counter saturated
frame_err  out  1  sticky short-slot error

Behaviour:
- Reset (async, active-high): data_l = data_r = 0, sample_valid = 0, wr = 0, addr = 0, full = 0, frame_err = 0, lrc_q = 1, bit counter idle, record_q = 0.
- lrc_q <= adclrc on every posedge. An edge is detected at posedge k when adclrc != lrc_q.
- Word start: MODE 1: the bit sampled at k is the MSB. MODE 0: the bit at k+1 is the MSB. The remaining DATA_W-1 bits follow on consecutive posedges, MSB-first, into a shift register.
- Channel select: a falling edge (1->0) starts the left word; a rising edge starts the right word.
- Frame acceptance: record_q is sampled at left-word start. If record_q is 0, that frame produces no sample_valid. A frame that has started completes even if record drops.
- Completion: on the posedge the right LSB is shifted in, data_l and data_r load together and sample_valid is asserted for exactly one bclk cycle. Latency from right-word MSB to sample_valid is DATA_W cycles.
- Short slot: if an LRC edge arrives before DATA_W bits of the current word are captured:
  - the partial word is discarded;
  - the frame is marked bad, so no sample_valid for it;
  - frame_err is set and stays set until reset;
  - the new word starts normally on that edge.
- Address: addr holds the address of the current wr. It increments by 1 after each wr. At 2^ADDR_W-1 the write that occurs sets full; addr holds there.
- While full, wr = 0 and sample_valid still pulses.
- A rising edge of record (record_q 0->1) clears addr and full in the same cycle. It takes priority over an increment in that cycle.
- Data outputs are raw two's-complement; no sign extension or rounding is applied.

Optional Feature:
Macro ADC_MIX_EN.
- Defined: adds output mix_data [DATA_W-1:0] = (signed data_l + signed data_r) >>> 1. The sum is computed DATA_W+1 wide, arithmetic-shifted, truncated, and registered alongside data_l/data_r so it updates on the same sample_valid. Reset value is 0.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- MODE 0, DATA_W 16, record=1, 32-bclk slots, L=16'h8001, R=16'h7FFE -> sample_valid single pulse; data_l=16'h8001, data_r=16'h7FFE; wr=1 with addr=0; next frame writes at addr=1.
- MODE 1, same words -> identical outputs. The same stimulus driven in MODE 0 framing gives data_l=16'h0002 (one-bit shift), proving the MSB alignment.
- Right slot cut to 10 bclk -> no sample_valid for that frame, frame_err=1 and sticky; the following good frame yields valid data.
- ADDR_W=3, record=1, 10 frames -> wr on addrs 0..7, full=1 after the 8th; frames 9-10 give sample_valid=1, wr=0; a record 0->1 toggle then gives addr=0, full=0.
- record driven low just before the left slot -> no valid. record raised mid-left-slot -> no valid for that frame. Reset asserted mid-word -> all outputs return to 0 immediately, and the next complete frame after release is correct.
- ADC_MIX_EN, L=16'h7FFF, R=16'h7FFF -> mix=16'h7FFF. L=16'h8000, R=16'h8000 -> mix=16'h8000. L=16'h0003, R=16'hFFFF -> mix=16'h0001.

Source files
------------

// File: rtl/i2s_adc_rx.sv
// i2s_adc_rx -- stereo I2S / left-justified serial ADC receiver.
//
// Runs entirely on the codec bit clock. Deserialises the left and right
// words of each LRC frame, presents them together with a one-cycle
// sample_valid strobe, and drives a saturating address / write strobe
// for the SRAM record buffer. Short slots are flagged in a sticky error.
//
// Parameters:
//   DATA_W  sample width per channel (8..24); extra slot bits ignored
//   ADDR_W  record buffer address width
//   MODE    0 = I2S (MSB one bclk after LRC edge), 1 = left-justified
//
// Ports:
//   bclk          in   bit clock, all logic on posedge
//   reset         in   asynchronous active-high reset
//   adclrc        in   LRC, low = left slot, high = right slot
//   adcdat        in   serial data, MSB first
//   record        in   record enable
//   data_l        out  last complete left sample
//   data_r        out  last complete right sample
//   sample_valid  out  one-bclk pulse per new L/R pair
//   wr            out  buffer write strobe
//   addr          out  buffer address for the current wr
//   full          out  address counter saturated
//   frame_err     out  sticky short-slot error
//   mix_data      out  (L+R)>>>1, present only with ADC_MIX_EN defined
//
// Optional feature macro: ADC_MIX_EN.

module i2s_adc_rx #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned MODE   = 0
) (
    input  logic              bclk,
    input  logic              reset,
    input  logic              adclrc,
    input  logic              adcdat,
    input  logic              record,
    output logic [DATA_W-1:0] data_l,
    output logic [DATA_W-1:0] data_r,
    output logic              sample_valid,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic              full,
    output logic              frame_err
`ifdef ADC_MIX_EN
    ,
    output logic [DATA_W-1:0] mix_data
`endif
);

    localparam int unsigned       CW   = $clog2(DATA_W);
    localparam logic [CW-1:0]     LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEFT,
        ST_RIGHT
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-2:0] sr;
    logic [DATA_W-1:0] left_hold;
    logic              lrc_q;
    logic              record_q;
    logic              frame_ok;

    logic              lrc_edge;
    logic              cap_old;
    logic              done_old;
    logic              short_slot;
    logic              shift_en;
    logic              rec_rise;
    logic [DATA_W-1:0] word;

    // In I2S mode the bit sampled on an LRC edge still belongs to the
    // outgoing word (its LSB); in left-justified mode it is the new MSB.
    always_comb begin
        lrc_edge   = adclrc ^ lrc_q;
        cap_old    = (state != ST_IDLE) && ((MODE == 0) || !lrc_edge);
        done_old   = cap_old && (cnt == LAST);
        short_slot = lrc_edge && (state != ST_IDLE) && !done_old;
        shift_en   = cap_old || (lrc_edge && (MODE == 1));
        word       = {sr, adcdat};
        rec_rise   = record & ~record_q;
    end

    assign wr = sample_valid & record_q & ~full;

`ifdef ADC_MIX_EN
    logic signed [DATA_W:0] mix_sum;
    always_comb begin
        mix_sum = $signed({left_hold[DATA_W-1], left_hold}) + $signed({word[DATA_W-1], word});
    end
`endif

    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            sr           <= '0;
            left_hold    <= '0;
            lrc_q        <= 1'b1;
            record_q     <= 1'b0;
            frame_ok     <= 1'b0;
            data_l       <= '0;
            data_r       <= '0;
            sample_valid <= 1'b0;
            addr         <= '0;
            full         <= 1'b0;
            frame_err    <= 1'b0;
`ifdef ADC_MIX_EN
            mix_data     <= '0;
`endif
        end else begin
            lrc_q        <= adclrc;
            record_q     <= record;
            sample_valid <= 1'b0;

            if (shift_en) begin
                sr <= word[DATA_W-2:0];
            end

            if (done_old) begin
                if (state == ST_LEFT) begin
                    left_hold <= word;
                end else if (frame_ok) begin
                    data_l       <= left_hold;
                    data_r       <= word;
                    sample_valid <= 1'b1;
`ifdef ADC_MIX_EN
                    mix_data     <= DATA_W'(mix_sum >>> 1);
`endif
                end
            end

            // A falling edge opens a new frame and re-evaluates acceptance,
            // which also abandons a frame whose right slot was cut short.
            if (lrc_edge) begin
                state <= adclrc ? ST_RIGHT : ST_LEFT;
                cnt   <= (MODE == 1) ? CW'(1) : CW'(0);
                if (short_slot) begin
                    frame_err <= 1'b1;
                end
                if (!adclrc) begin
                    frame_ok <= record_q;
                end else if (short_slot) begin
                    frame_ok <= 1'b0;
                end
            end else if (cap_old) begin
                if (done_old) begin
                    state <= ST_IDLE;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end

            if (rec_rise) begin
                addr <= '0;
                full <= 1'b0;
            end else if (wr) begin
                if (addr == '1) begin
                    full <= 1'b1;
                end else begin
                    addr <= addr + ADDR_W'(1);
                end
            end
        end
    end

endmodule
